nn_input_feeder: RTL and testbench

Upstream loader for the neural-network core. It accepts one labelled sample per frame from a host stream: a 2-bit class label, then 225 8-bit pixels of a 15x15 image. It converts these into the core's write interfaces: pixel data/wraddress/wren and supervisor sprdata/spraddress/spren. It also drives the core's back_en per frame and stalls the host whenever the core deasserts request_in.

---
 rtl/nn_input_feeder.sv | 194 +++++++++++++++++++
 tb/tb_nn_input_feeder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_input_feeder.sv
// ---------------------------------------------------------------------------
// nn_input_feeder
//
// Takes one labelled sample per frame from a host stream and converts it into
// the neural-network core's write interfaces. A frame is a 2-bit class label
// followed by NPIX 8-bit pixels of a row-major 15x15 image.
//   - The label produces three supervisor writes (spraddress 0..2). The
//     labelled class gets SPR_HI and the other classes get SPR_LO.
//   - Each pixel produces one pixel write of {1'b0, pix, 7'b0}. This is the
//     Q1.15 value pix/256.
//   - At the end of the frame, back_en is updated, frame_done pulses and
//     frame_cnt increments.
// The host is stalled whenever the core deasserts request_in.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   label_in/_valid/_ready    label handshake (ready only in IDLE)
//   pix_in/_valid/_ready      pixel handshake (ready only in PIX)
//   request_in                core permits writes this cycle
//   data/wraddress/wren       registered pixel write port to the core
//   sprdata/spraddress/spren  registered supervisor write port to the core
//   back_en                   1 = core trains on the current frame
//   frame_done                one-cycle pulse after the last pixel write
//   frame_cnt                 completed frames, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module nn_input_feeder #(
    parameter int unsigned NPIX   = 225,
    parameter logic [15:0] SPR_HI = 16'h7000,
    parameter logic [15:0] SPR_LO = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  label_in,
    input  logic        label_valid,
    output logic        label_ready,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        request_in,
    output logic [15:0] data,
    output logic [7:0]  wraddress,
    output logic        wren,
    output logic [15:0] sprdata,
    output logic [1:0]  spraddress,
    output logic        spren,
    output logic        back_en,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SPR,
        PIX,
        DONE
    } state_t;

    localparam logic [7:0] LAST_PIX = 8'(NPIX - 1);
    localparam logic [1:0] LAST_SPR = 2'd2;
    localparam logic [1:0] NO_LABEL = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  label_q, label_d;
    logic [1:0]  spr_idx_q, spr_idx_d;
    logic [7:0]  pix_idx_q, pix_idx_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  wraddress_q, wraddress_d;
    logic        wren_q, wren_d;
    logic [15:0] sprdata_q, sprdata_d;
    logic [1:0]  spraddress_q, spraddress_d;
    logic        spren_q, spren_d;
    logic        back_en_q, back_en_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default before the case.
        // Without these defaults, any path that skips an assignment would
        // infer a latch.
        state_d      = state_q;
        label_d      = label_q;
        spr_idx_d    = spr_idx_q;
        pix_idx_d    = pix_idx_q;
        data_d       = data_q;
        wraddress_d  = wraddress_q;
        wren_d       = 1'b0;
        sprdata_d    = sprdata_q;
        spraddress_d = spraddress_q;
        spren_d      = 1'b0;
        back_en_d    = back_en_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        label_ready  = 1'b0;
        pix_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                label_ready = request_in;
                if (label_valid && request_in) begin
                    label_d   = label_in;
                    spr_idx_d = 2'd0;
                    state_d   = SPR;
                end
            end

            // One supervisor write per cycle while the core allows it.
            // A low request_in freezes spr_idx, so the write sequence
            // resumes where it stopped.
            SPR: begin
                if (request_in) begin
                    spren_d      = 1'b1;
                    spraddress_d = spr_idx_q;
                    sprdata_d    = (spr_idx_q == label_q) ? SPR_HI : SPR_LO;
                    if (spr_idx_q == LAST_SPR) begin
                        pix_idx_d = 8'd0;
                        state_d   = PIX;
                    end else begin
                        spr_idx_d = spr_idx_q + 2'd1;
                    end
                end
            end

            PIX: begin
                pix_ready = request_in;
                if (pix_valid && request_in) begin
                    wren_d      = 1'b1;
                    data_d      = {1'b0, pix_in, 7'b0};
                    wraddress_d = pix_idx_q;
                    pix_idx_d   = pix_idx_q + 8'd1;
                    if (pix_idx_q == LAST_PIX) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 16'd1;
                back_en_d    = (label_q != NO_LABEL);
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register therefore samples its _d value from the same clock edge.
    // The data and address registers are plain flops, not a memory, so
    // resetting them costs nothing. Clearing them gives the core a clean,
    // defined bus after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            label_q      <= NO_LABEL;
            spr_idx_q    <= 2'd0;
            pix_idx_q    <= 8'd0;
            data_q       <= 16'd0;
            wraddress_q  <= 8'd0;
            wren_q       <= 1'b0;
            sprdata_q    <= 16'd0;
            spraddress_q <= 2'd0;
            spren_q      <= 1'b0;
            back_en_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            label_q      <= label_d;
            spr_idx_q    <= spr_idx_d;
            pix_idx_q    <= pix_idx_d;
            data_q       <= data_d;
            wraddress_q  <= wraddress_d;
            wren_q       <= wren_d;
            sprdata_q    <= sprdata_d;
            spraddress_q <= spraddress_d;
            spren_q      <= spren_d;
            back_en_q    <= back_en_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign data       = data_q;
    assign wraddress  = wraddress_q;
    assign wren       = wren_q;
    assign sprdata    = sprdata_q;
    assign spraddress = spraddress_q;
    assign spren      = spren_q;
    assign back_en    = back_en_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_nn_input_feeder.sv
// ---------------------------------------------------------------------------
// tb_nn_input_feeder
//
// Self-checking bench for nn_input_feeder.
// - The host driver sends labelled frames and pushes the expected write
//   sequence for each frame into scoreboards.
// - A monitor matches every spren/wren strobe against those scoreboards in
//   order.
// - At each frame_done, the monitor checks frame_cnt and back_en against a
//   simple frame-level model.
// ---------------------------------------------------------------------------
module tb_nn_input_feeder;

    localparam int          NPIX   = 225;
    localparam logic [15:0] SPR_HI = 16'h7000;
    localparam logic [15:0] SPR_LO = 16'h0000;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  label_in;
    logic        label_valid;
    logic        label_ready;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        request_in;
    logic [15:0] data;
    logic [7:0]  wraddress;
    logic        wren;
    logic [15:0] sprdata;
    logic [1:0]  spraddress;
    logic        spren;
    logic        back_en;
    logic        frame_done;
    logic [15:0] frame_cnt;

    nn_input_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .label_in   (label_in),
        .label_valid(label_valid),
        .label_ready(label_ready),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .request_in (request_in),
        .data       (data),
        .wraddress  (wraddress),
        .wren       (wren),
        .sprdata    (sprdata),
        .spraddress (spraddress),
        .spren      (spren),
        .back_en    (back_en),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state.
    wr_t         exp_spr[$];
    wr_t         exp_pix[$];
    logic [15:0] exp_cnt   = 16'd0;
    logic        exp_back  = 1'b0;
    logic [1:0]  cur_label = 2'd3;
    int          total     = 0;
    int          bad       = 0;
    int          cyc       = 0;
    int          done_seen = 0;
    int          first_spr  = -1;
    int          first_wren = -1;
    int          fd_cyc     = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    // req_edge and rst_edge hold the values in effect during the launching cycle.
    logic req_edge, rst_edge, prev_fd = 1'b0;
    wr_t  mon_e;

    always @(posedge clk) begin
        req_edge = request_in;
        rst_edge = rst;
        cyc++;
        #2;
        if (rst_edge) begin
            check("rst_wren", 32'(wren), 32'd0);
            check("rst_spren", 32'(spren), 32'd0);
            check("rst_fd", 32'(frame_done), 32'd0);
            check("rst_back", 32'(back_en), 32'd0);
            check("rst_cnt", 32'(frame_cnt), 32'd0);
            check("rst_data", 32'(data), 32'd0);
            check("rst_wraddr", 32'(wraddress), 32'd0);
            check("rst_sprdata", 32'(sprdata), 32'd0);
            check("rst_spraddr", 32'(spraddress), 32'd0);
            check("rst_lrdy", 32'(label_ready), 32'(request_in));
        end else begin
            if (spren) begin
                check("spr_req", 32'(req_edge), 32'd1);
                if (first_spr < 0) first_spr = cyc;
                if (exp_spr.size() == 0) begin
                    check("spr_extra", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_spr.pop_front();
                    check("spr_addr", 32'(spraddress), 32'(mon_e.addr));
                    check("spr_data", 32'(sprdata), 32'(mon_e.data));
                end
            end
            if (wren) begin
                check("pix_req", 32'(req_edge), 32'd1);
                if (first_wren < 0) first_wren = cyc;
                if (exp_pix.size() == 0) begin
                    check("pix_extra", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_pix.pop_front();
                    check("pix_addr", 32'(wraddress), 32'(mon_e.addr));
                    check("pix_data", 32'(data), 32'(mon_e.data));
                end
            end
            if (frame_done) begin
                check("fd_pulse", 32'(prev_fd), 32'd0);
                check("fd_spr_left", 32'(exp_spr.size()), 32'd0);
                check("fd_pix_left", 32'(exp_pix.size()), 32'd0);
                exp_cnt  = exp_cnt + 16'd1;
                exp_back = (cur_label != 2'd3);
                check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
                fd_cyc = cyc;
                done_seen++;
            end
            check("back_en", 32'(back_en), 32'(exp_back));
        end
        prev_fd = frame_done;
    end

    task automatic drive_req(input bit rnd);
        request_in = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
    endtask

    // Sends one frame.
    //   pat      : 0 = pixel value equals its index, 1 = random values
    //   stall_px : pixel index at which request_in drops for 5 cycles (-1 = none)
    //   spr_stall: drop request_in right after supervisor index 0 is written
    //   rst_px   : pixel index at which rst is asserted (-1 = none)
    //   rnd      : random valid gaps and random request_in drops
    //   timed    : check the exact latencies of an uninterrupted frame
    task automatic run_frame(input logic [1:0] l, input int pat, input int stall_px,
                             input bit spr_stall, input int rst_px, input bit rnd,
                             input bit timed);
        logic [7:0] vals [NPIX];
        int n;
        int t0;
        int d0;
        for (int i = 0; i < NPIX; i++)
            vals[i] = (pat == 0) ? 8'(i) : 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++)
            exp_spr.push_back(wr_t'{addr: 8'(i), data: (i == int'(l)) ? SPR_HI : SPR_LO});
        for (int i = 0; i < NPIX; i++)
            exp_pix.push_back(wr_t'{addr: 8'(i), data: 16'(vals[i]) << 7});
        cur_label  = l;
        first_spr  = -1;
        first_wren = -1;
        d0 = done_seen;

        @(negedge clk);
        label_in    = l;
        label_valid = 1'b1;
        drive_req(rnd);
        n = 0;
        forever begin
            #1;
            if (label_ready) break;
            n++;
            if (n > 100) begin
                check("label_timeout", 32'd0, 32'd1);
                label_valid = 1'b0;
                return;
            end
            @(negedge clk);
            drive_req(rnd);
        end
        @(negedge clk);
        label_valid = 1'b0;
        label_in    = 2'($urandom_range(0, 3));
        t0 = cyc;
        drive_req(rnd);

        if (spr_stall) begin
            @(negedge clk);
            request_in = 1'b0;
            repeat (4) @(negedge clk);
            check("spr_gap_left", 32'(exp_spr.size()), 32'd2);
            request_in = 1'b1;
        end

        for (int i = 0; i < NPIX; i++) begin
            if (rnd) begin
                while ($urandom_range(0, 3) == 0) begin
                    pix_valid = 1'b0;
                    drive_req(rnd);
                    @(negedge clk);
                end
            end
            pix_in    = vals[i];
            pix_valid = 1'b1;
            if (i == rst_px) begin
                rst     = 1'b1;
                exp_cnt = 16'd0;
                @(negedge clk);
                check("rst_mid_wren", 32'(wren), 32'd0);
                check("rst_mid_cnt", 32'(frame_cnt), 32'(exp_cnt));
                check("rst_mid_fd", 32'(frame_done), 32'd0);
                rst       = 1'b0;
                pix_valid = 1'b0;
                exp_back  = 1'b0;
                exp_spr.delete();
                exp_pix.delete();
                return;
            end
            if (i == stall_px) begin
                request_in = 1'b0;
                repeat (5) begin
                    #1;
                    check("stall_prdy", 32'(pix_ready), 32'd0);
                    @(negedge clk);
                end
                check("stall_left", 32'(exp_pix.size()), 32'(NPIX - stall_px));
            end
            drive_req(rnd);
            n = 0;
            forever begin
                #1;
                check("lrdy_busy", 32'(label_ready), 32'd0);
                if (pix_ready) break;
                n++;
                if (n > 100) begin
                    check("pix_timeout", 32'd0, 32'd1);
                    pix_valid = 1'b0;
                    return;
                end
                @(negedge clk);
                drive_req(rnd);
            end
            @(negedge clk);
        end
        pix_valid  = 1'b0;
        request_in = 1'b1;

        n = 0;
        while (done_seen == d0) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                check("fd_timeout", 32'd0, 32'd1);
                return;
            end
        end
        if (timed) begin
            check("lat_spr", 32'(first_spr - t0), 32'd1);
            check("lat_wren", 32'(first_wren - t0), 32'd4);
            check("lat_fd", 32'(fd_cyc - t0), 32'd229);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        label_in    = 2'd0;
        label_valid = 1'b0;
        pix_in      = 8'd0;
        pix_valid   = 1'b0;
        request_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        request_in = 1'b1;

        // Reset at pixel 50, then a full frame with label 1 and pixel value = index.
        run_frame(2'd1, 0, -1, 1'b0, 50, 1'b0, 1'b0);
        run_frame(2'd1, 0, -1, 1'b0, -1, 1'b0, 1'b1);
        // Unlabelled frame with random pixels and random flow control.
        run_frame(2'd3, 1, -1, 1'b0, -1, 1'b1, 1'b0);
        // request_in drops for 5 cycles at pixel 100.
        run_frame(2'd0, 1, 100, 1'b0, -1, 1'b0, 1'b0);
        // request_in drops in the SPR phase after index 0.
        run_frame(2'd2, 1, -1, 1'b1, -1, 1'b0, 1'b0);

        // Preset frame_cnt to 16'hFFFF so the next frame must wrap it to 0.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        check("preset_cnt", 32'(frame_cnt), 32'h0000FFFF);
        run_frame(2'd0, 1, -1, 1'b0, -1, 1'b0, 1'b1);
        check("wrap_cnt", 32'(frame_cnt), 32'd0);

        // Random frames.
        for (int k = 0; k < 2; k++)
            run_frame(2'($urandom_range(0, 3)), 1, -1, 1'b0, -1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
